// File: rtl/cpu_pkg.sv
// Shared constants and types for the moxie writeback path.
package cpu_pkg;
  localparam int REG_COUNT = 16;
  localparam int IDX_W     = 4;
  localparam int DATA_W    = 32;

  localparam logic [IDX_W-1:0] REG_FP = 4'd0;
  localparam logic [IDX_W-1:0] REG_SP = 4'd1;

  typedef struct packed {
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] value;
  } wb_entry_t;
endpackage

// File: rtl/cpu_writeback_if.sv
// Retire handshake plus register-file write port of the writeback block.
interface cpu_writeback_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
);
  logic              valid_i;
  logic              ready_o;
  logic              wr_a_en_i;
  logic [IDX_W-1:0]  wr_a_index_i;
  logic [DATA_W-1:0] wr_a_value_i;
  logic              wr_b_en_i;
  logic [IDX_W-1:0]  wr_b_index_i;
  logic [DATA_W-1:0] wr_b_value_i;
  logic              write_enable_o;
  logic [IDX_W-1:0]  reg_write_index_o;
  logic [DATA_W-1:0] value_o;
  logic [15:0]       pending_mask_o;
  logic              idle_o;

  modport master (
    output valid_i, wr_a_en_i, wr_a_index_i, wr_a_value_i,
           wr_b_en_i, wr_b_index_i, wr_b_value_i,
    input  ready_o, write_enable_o, reg_write_index_o, value_o,
           pending_mask_o, idle_o
  );

  modport slave (
    input  valid_i, wr_a_en_i, wr_a_index_i, wr_a_value_i,
           wr_b_en_i, wr_b_index_i, wr_b_value_i,
    output ready_o, write_enable_o, reg_write_index_o, value_o,
           pending_mask_o, idle_o
  );
endinterface

// File: rtl/cpu_wb_fifo.sv
// Dual-push / single-pop circular buffer; pops every cycle it is non-empty
// because the register-file write port never stalls.
module cpu_wb_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 32,
  parameter  int IDX_W  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    push_cnt,
  input  logic [1:0][IDX_W-1:0]         push_idx,
  input  logic [1:0][DATA_W-1:0]        push_val,
  output logic [CNT_W-1:0]              count,
  output logic [IDX_W-1:0]              head_idx,
  output logic [DATA_W-1:0]             head_val,
  output logic [DEPTH-1:0]              ent_vld,
  output logic [DEPTH-1:0][IDX_W-1:0]   ent_idx
);
  logic [DEPTH-1:0][IDX_W-1:0]  idx_q;
  logic [DEPTH-1:0][DATA_W-1:0] val_q;
  logic [PTR_W-1:0]             rptr, wptr, wptr1;
  logic                         pop;

  assign pop   = (count != '0);
  assign wptr1 = wptr + PTR_W'(1);

  // Storage is not reset; ent_vld alone decides what is live.
  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) begin
      idx_q[wptr] <= push_idx[0];
      val_q[wptr] <= push_val[0];
    end
    if (push_cnt == 2'd2) begin
      idx_q[wptr1] <= push_idx[1];
      val_q[wptr1] <= push_val[1];
    end
  end

  // Push slots never alias the popped slot: a push needs two free entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr    <= '0;
      wptr    <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (pop) begin
        ent_vld[rptr] <= 1'b0;
        rptr          <= rptr + PTR_W'(1);
      end
      if (push_cnt != 2'd0) ent_vld[wptr]  <= 1'b1;
      if (push_cnt == 2'd2) ent_vld[wptr1] <= 1'b1;
      wptr  <= wptr + PTR_W'(push_cnt);
      count <= count + CNT_W'(push_cnt) - CNT_W'(pop);
    end
  end

  assign head_idx = idx_q[rptr];
  assign head_val = val_q[rptr];
  assign ent_idx  = idx_q;
endmodule

// File: rtl/cpu_writeback.sv
// Writeback initiator: queues up to two register writes per retiring
// instruction and drains them to the register file one per cycle.
module cpu_writeback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  cpu_writeback_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]             count;
  logic                         ready, accept, busy;
  logic [1:0]                   push_cnt;
  logic [1:0][IDX_W-1:0]        push_idx;
  logic [1:0][DATA_W-1:0]       push_val;
  logic [IDX_W-1:0]             head_idx;
  logic [DATA_W-1:0]            head_val;
  logic [DEPTH-1:0]             ent_vld;
  logic [DEPTH-1:0][IDX_W-1:0]  ent_idx;
  logic [15:0]                  mask;

  // Room for a full pair is required regardless of what is offered.
  assign ready  = (count <= CNT_W'(DEPTH - 2));
  assign accept = bus.valid_i && ready;
  assign busy   = (count != '0);

  // Pack enabled writes into consecutive slots, A ahead of B.
  always_comb begin
    push_cnt = 2'd0;
    push_idx = '0;
    push_val = '0;
    if (accept) begin
      if (bus.wr_a_en_i) begin
        push_idx[0] = bus.wr_a_index_i;
        push_val[0] = bus.wr_a_value_i;
        if (bus.wr_b_en_i) begin
          push_idx[1] = bus.wr_b_index_i;
          push_val[1] = bus.wr_b_value_i;
          push_cnt    = 2'd2;
        end else begin
          push_cnt    = 2'd1;
        end
      end else if (bus.wr_b_en_i) begin
        push_idx[0] = bus.wr_b_index_i;
        push_val[0] = bus.wr_b_value_i;
        push_cnt    = 2'd1;
      end
    end
  end

  cpu_wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_fifo (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .push_cnt (push_cnt),
    .push_idx (push_idx),
    .push_val (push_val),
    .count    (count),
    .head_idx (head_idx),
    .head_val (head_val),
    .ent_vld  (ent_vld),
    .ent_idx  (ent_idx)
  );

  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_vld[i]) mask[ent_idx[i]] = 1'b1;
  end

  assign bus.ready_o           = ready;
  assign bus.idle_o            = !busy;
  assign bus.write_enable_o    = busy;
  assign bus.reg_write_index_o = busy ? head_idx : '0;
  assign bus.value_o           = busy ? head_val : '0;
  assign bus.pending_mask_o    = mask;
endmodule
